tjg_seq_multiplier: RTL and testbench
=====================================

# tjg_seq_multiplier

Parametrised sequential shift-add multiplier with start/done handshake, signed/unsigned mode and truncation overflow flag. Next generation of the lab fixed-width 6x4 multiplier: operands come from ports rather than a selector, widths are parameters, and two's-complement operands are supported. Sits behind any datapath controller that needs a low-area multiply at one multiplier bit per clock.

## Interface
- A_W, 6, multiplicand width (>= 2)
- B_W, 4, multiplier width (>= 2); also the iteration count
- P_W, A_W+B_W, product output width (2 <= P_W <= A_W+B_W); narrower values truncate
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising edge of clock
- mode_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with operands
- a  in  A_W  multiplicand; latched on accepted start
- b  in  B_W  multiplier; latched on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when product is valid
- product  out  P_W  low P_W bits of full product; held until next accepted start's completion
- cout  out  1  overflow: full product not representable in P_W bits (for the latched mode)

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: start=1 -> latch a, b, mode_signed; clear accumulator and iteration counter; -> RUN.
- RUN: per edge, examine multiplier bit i (LSB first). Bit set: add multiplicand (sign-extended in signed mode, zero-extended otherwise) shifted by i to accumulator. In signed mode, bit B_W-1 set subtracts instead of adds. After bit B_W-1 -> DONE.
- DONE: product and cout update, done=1 for exactly this cycle. start=1 here is accepted (back-to-back) -> RUN with new operands; otherwise -> IDLE.
- start during RUN is ignored; no queueing.
- Accumulator width A_W+B_W (+1 guard bit for signed subtraction); full product always exact.
- cout: unsigned -> any full-product bit above P_W-1 set; signed -> discarded high bits are not all equal to bit P_W-1. With P_W = A_W+B_W, cout is always 0.
- product/cout change only on the DONE-entry edge; stable otherwise, including during a following RUN.

## Timing
- Reset values: busy=0, done=0, product=0, cout=0, state IDLE, counter 0.
- start accepted at edge E0 -> busy high after E0; done high after edge E0+B_W, low after E0+B_W+1.
- Latency start-to-done: B_W+1 edges (default 5). Throughput with back-to-back start held high: one result per B_W+1 cycles.
- reset asserted mid-RUN: immediate return to IDLE, all outputs to reset values, operation discarded; no done.
- start and reset together: reset wins.
- Operand ports may change freely after the accepting edge.

## Structure
- Shared package tjg_mult_pkg: state encoding (IDLE/RUN/DONE), counter width function clog2(B_W+1).
- Sub-module tjg_mult_ctrl: FSM, iteration counter, busy/done generation; datapath (operand registers, accumulator, overflow check) in the top module.

## Test plan
- Reset, then unsigned a=0, b=0 -> done after 5 edges, product=0, cout=0; busy high 4 cycles.
- Unsigned a=63, b=15 -> product=945 (0x3B1); a=21,b=5 -> 105; a=42,b=10 -> 420; a=21,b=10 -> 210; all cout=0.
- Signed a=-1 (0x3F), b=-1 (0xF) -> product=1; a=-32, b=-8 -> product=256; a=-32, b=7 -> product=-224 (0x320).
- P_W=8, unsigned 63x15 -> product=0xB1, cout=1; unsigned 15x15 -> product=225, cout=0; signed 5x-3 -> 0xF1, cout=0.
- start held high across DONE -> second operation begins immediately, done pulses every 5 cycles; start pulse during RUN ignored, result unchanged.
- reset asserted 2 cycles into RUN -> outputs zero immediately, no done; next start completes normally with correct product.

Source files
------------

// File: rtl/tjg_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the iteration-counter width helper.
package tjg_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold 0..B_W, since it steps once past the last bit index.
  function automatic int cnt_w(input int b_w);
    return $clog2(b_w + 1);
  endfunction

endpackage

// File: rtl/tjg_seq_multiplier_if.sv
// Request/result bundle between a datapath controller and the multiplier.
//
// Handshake: the requester raises start with a, b and mode_signed valid; the
// multiplier accepts it on a rising clock edge only while idle or in its done
// cycle (busy=0). Operands may change freely after the accepting edge. The
// result is valid in the single cycle where done=1, and product/cout then hold
// until the next accepted request completes. start while busy=1 is dropped.
interface tjg_seq_multiplier_if #(
  parameter int A_W = 6,
  parameter int B_W = 4,
  parameter int P_W = A_W + B_W
);
  logic           start;
  logic           mode_signed;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           busy;
  logic           done;
  logic [P_W-1:0] product;
  logic           cout;

  modport master (
    output start, mode_signed, a, b,
    input  busy, done, product, cout
  );

  modport slave (
    input  start, mode_signed, a, b,
    output busy, done, product, cout
  );
endinterface

// File: rtl/tjg_mult_ctrl.sv
// Control FSM for the multiplier: sequences IDLE -> RUN (one multiplier bit
// per clock) -> DONE, owns the bit-index counter and produces busy/done plus
// the load/step/last strobes that steer the datapath.
module tjg_mult_ctrl
  import tjg_mult_pkg::*;
#(
  parameter  int B_W = 4,
  localparam int CW  = cnt_w(B_W)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          load_o,
  output logic          step_o,
  output logic          last_o,
  output logic [CW-1:0] bit_idx_o,
  output state_t        state_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(B_W - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset drops any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          load_o  = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_d = '0;
        // A request in the result cycle starts the next operation directly.
        if (start_i) begin
          state_d = ST_RUN;
          load_o  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);
  assign step_o    = (state_q == ST_RUN);
  assign last_o    = (state_q == ST_RUN) && (cnt_q == LAST_IDX);
  assign bit_idx_o = cnt_q;
  assign state_o   = state_q;

endmodule

// File: rtl/tjg_seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock. Supports
// unsigned and two's-complement operands; the product is truncated to P_W
// bits with cout flagging a full product that does not fit.
module tjg_seq_multiplier
  import tjg_mult_pkg::*;
#(
  parameter int A_W = 6,
  parameter int B_W = 4,
  parameter int P_W = A_W + B_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tjg_seq_multiplier_if.slave   bus,
  output state_t                dbg_state_o
);

  localparam int FW    = A_W + B_W;
  localparam int ACC_W = FW + 1;
  localparam int CW    = cnt_w(B_W);

  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic             sgn_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [P_W-1:0]   product_q, product_d;
  logic             cout_q, cout_d;

  logic             load, step, last;
  logic [CW-1:0]    bit_idx;

  logic [ACC_W-1:0]      a_ext;
  logic [ACC_W-1:0]      addend;
  logic                  bit_set;
  logic                  sub_op;
  logic [FW-1:0]         full;
  logic [FW-1:0]         hi_u;
  logic signed [FW-1:0]  hi_s;
  logic                  ovf;

  tjg_mult_ctrl #(
    .B_W (B_W)
  ) u_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (bus.start),
    .busy_o    (bus.busy),
    .done_o    (bus.done),
    .load_o    (load),
    .step_o    (step),
    .last_o    (last),
    .bit_idx_o (bit_idx),
    .state_o   (dbg_state_o)
  );

  // Partial-product selection: extended multiplicand shifted to the current
  // bit weight; in signed mode the sign bit of b carries negative weight.
  always_comb begin
    a_ext   = sgn_q ? {{(ACC_W-A_W){a_q[A_W-1]}}, a_q}
                    : {{(ACC_W-A_W){1'b0}}, a_q};
    addend  = a_ext << bit_idx;
    bit_set = |(b_q & (B_W'(1) << bit_idx));
    sub_op  = sgn_q && last;
  end

  // Accumulator update and result capture on the final bit.
  always_comb begin
    acc_d     = acc_q;
    product_d = product_q;
    cout_d    = cout_q;
    if (load) begin
      acc_d = '0;
    end else if (step && bit_set) begin
      acc_d = sub_op ? (acc_q - addend) : (acc_q + addend);
    end
    full = acc_d[FW-1:0];
    // Unsigned: anything above bit P_W-1 is lost. Signed: the dropped bits
    // plus the new sign bit must all agree for the value to survive.
    hi_u = full >> P_W;
    hi_s = $signed(full) >>> (P_W - 1);
    ovf  = sgn_q ? !((hi_s == '0) || (hi_s == '1)) : (hi_u != '0);
    if (last) begin
      product_d = full[P_W-1:0];
      cout_d    = ovf;
    end
  end

  // Operand latches, accumulator and held result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      if (load) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        sgn_q <= bus.mode_signed;
      end
      acc_q     <= acc_d;
      product_q <= product_d;
      cout_q    <= cout_d;
    end
  end

  assign bus.product = product_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_tjg_seq_multiplier.sv
// Bench for tjg_seq_multiplier: two instances (full-width and 8-bit product)
// share stimulus; a behavioural model predicts busy/done/product/cout.
module tb_tjg_seq_multiplier;
  import tjg_mult_pkg::*;

  localparam int A_W  = 6;
  localparam int B_W  = 4;
  localparam int PW_A = 10;
  localparam int PW_B = 8;

  // ---------------- clock / reset ----------------
  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           start = 1'b0;
  logic           mode  = 1'b0;
  logic [A_W-1:0] a     = '0;
  logic [B_W-1:0] b     = '0;

  always #5 clk = ~clk;

  tjg_seq_multiplier_if #(.A_W(A_W), .B_W(B_W), .P_W(PW_A)) bus_a ();
  tjg_seq_multiplier_if #(.A_W(A_W), .B_W(B_W), .P_W(PW_B)) bus_b ();

  assign bus_a.start = start;
  assign bus_a.mode_signed = mode;
  assign bus_a.a = a;
  assign bus_a.b = b;
  assign bus_b.start = start;
  assign bus_b.mode_signed = mode;
  assign bus_b.a = a;
  assign bus_b.b = b;

  state_t st_a, st_b;

  tjg_seq_multiplier #(.A_W(A_W), .B_W(B_W), .P_W(PW_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a), .dbg_state_o(st_a)
  );
  tjg_seq_multiplier #(.A_W(A_W), .B_W(B_W), .P_W(PW_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b), .dbg_state_o(st_b)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exact mathematical product, truncated, plus representability test.
  function automatic void golden(input logic sgn, input logic [A_W-1:0] aa,
                                 input logic [B_W-1:0] bb, input int pw,
                                 output logic [31:0] p, output logic c);
    longint fa, fb, full, lim;
    if (sgn) begin
      fa = longint'($signed(aa));
      fb = longint'($signed(bb));
    end else begin
      fa = longint'(aa);
      fb = longint'(bb);
    end
    full = fa * fb;
    p    = 32'(full & ((longint'(1) << pw) - 1));
    if (sgn) begin
      lim = longint'(1) << (pw - 1);
      c   = (full < -lim) || (full > lim - 1);
    end else begin
      c   = full >= (longint'(1) << pw);
    end
  endfunction

  // Behavioural model: an accepted request yields its result B_W edges later;
  // requests are only taken when no operation is outstanding.
  logic [31:0] exp_pa = '0, exp_pb = '0, pend_pa = '0, pend_pb = '0;
  logic        exp_ca = 1'b0, exp_cb = 1'b0, pend_ca = 1'b0, pend_cb = 1'b0;
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  int          left = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] p1, p2;
    logic        c1, c2;
    if (rst) begin
      exp_pa <= '0; exp_pb <= '0; exp_ca <= 1'b0; exp_cb <= 1'b0;
      exp_busy <= 1'b0; exp_done <= 1'b0; left <= 0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) begin
        exp_busy <= 1'b0; exp_done <= 1'b1;
        exp_pa <= pend_pa; exp_pb <= pend_pb;
        exp_ca <= pend_ca; exp_cb <= pend_cb;
      end else begin
        exp_done <= 1'b0;
      end
    end else begin
      exp_done <= 1'b0;
      if (start) begin
        golden(mode, a, b, PW_A, p1, c1);
        golden(mode, a, b, PW_B, p2, c2);
        pend_pa <= p1; pend_ca <= c1;
        pend_pb <= p2; pend_cb <= c2;
        left <= B_W;
        exp_busy <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle compare on the inactive edge.
  always @(negedge clk) begin
    check("busy_a", 32'(bus_a.busy), 32'(exp_busy));
    check("done_a", 32'(bus_a.done), 32'(exp_done));
    check("prod_a", 32'(bus_a.product), exp_pa);
    check("cout_a", 32'(bus_a.cout), 32'(exp_ca));
    check("busy_b", 32'(bus_b.busy), 32'(exp_busy));
    check("done_b", 32'(bus_b.done), 32'(exp_done));
    check("prod_b", 32'(bus_b.product), exp_pb);
    check("cout_b", 32'(bus_b.cout), 32'(exp_cb));
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input string name, input logic sgn, input logic [A_W-1:0] aa,
                        input logic [B_W-1:0] bb, input logic [31:0] pa, input logic [31:0] pb,
                        input logic cb);
    int lat, busy_cnt;
    @(negedge clk);
    mode = sgn; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = A_W'($urandom); b = B_W'($urandom); mode = 1'($urandom);
    lat = 1;
    busy_cnt = int'(bus_a.busy);
    while (!bus_a.done && lat < 20) begin
      @(negedge clk);
      lat++;
      busy_cnt += int'(bus_a.busy);
    end
    check({name, "_latency"}, 32'(lat), 32'(B_W + 1));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(B_W));
    check({name, "_p10"}, 32'(bus_a.product), pa);
    check({name, "_c10"}, 32'(bus_a.cout), 32'd0);
    check({name, "_p8"}, 32'(bus_b.product), pb);
    check({name, "_c8"}, 32'(bus_b.cout), 32'(cb));
    check({name, "_model"}, exp_pa, pa);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus_a.busy), 32'd0);
    check("reset_done", 32'(bus_a.done), 32'd0);
    check("reset_prod", 32'(bus_a.product), 32'd0);
    check("reset_state", 32'(st_a), 32'(ST_IDLE));
    #1 rst = 1'b0;

    run_op("u0x0",   1'b0, 6'd0,  4'd0,  32'd0,     32'd0,    1'b0);
    run_op("u63x15", 1'b0, 6'd63, 4'd15, 32'd945,   32'hB1,   1'b1);
    run_op("u21x5",  1'b0, 6'd21, 4'd5,  32'd105,   32'd105,  1'b0);
    run_op("u42x10", 1'b0, 6'd42, 4'd10, 32'd420,   32'hA4,   1'b1);
    run_op("u21x10", 1'b0, 6'd21, 4'd10, 32'd210,   32'd210,  1'b0);
    run_op("u15x15", 1'b0, 6'd15, 4'd15, 32'd225,   32'd225,  1'b0);
    run_op("s_m1m1", 1'b1, 6'h3F, 4'hF,  32'd1,     32'd1,    1'b0);
    run_op("s_m32m8",1'b1, 6'h20, 4'h8,  32'h100,   32'h00,   1'b1);
    run_op("s_m32x7",1'b1, 6'h20, 4'h7,  32'h320,   32'h20,   1'b1);
    run_op("s5xm3",  1'b1, 6'd5,  4'hD,  32'h3F1,   32'hF1,   1'b0);

    // Back-to-back: start held high, done every B_W+1 cycles.
    begin
      int d1, d2;
      d1 = 0; d2 = 0;
      @(negedge clk);
      mode = 1'b0; a = 6'd21; b = 4'd5; start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (bus_a.done) begin
          if (d1 == 0) d1 = i; else d2 = i;
        end
        if (i == 10) start = 1'b0;
      end
      check("b2b_first_done", 32'(d1), 32'd5);
      check("b2b_second_done", 32'(d2), 32'd10);
      check("b2b_prod", 32'(bus_a.product), 32'd105);
      repeat (3) @(negedge clk);
    end

    // Start pulse during RUN is ignored.
    @(negedge clk);
    mode = 1'b0; a = 6'd63; b = 4'd15; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 6'd1; b = 4'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign_done", 32'(bus_a.done), 32'd1);
    check("ign_prod", 32'(bus_a.product), 32'd945);
    @(negedge clk);
    check("ign_idle_after", 32'(bus_a.busy), 32'd0);

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    mode = 1'b0; a = 6'd42; b = 4'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_prod", 32'(bus_a.product), 32'd0);
    check("rst_cout8", 32'(bus_b.cout), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    begin
      int dcount;
      dcount = 0;
      repeat (6) begin
        @(negedge clk);
        dcount += int'(bus_a.done);
      end
      check("rst_no_done", 32'(dcount), 32'd0);
    end
    run_op("after_rst", 1'b0, 6'd21, 4'd10, 32'd210, 32'd210, 1'b0);

    // Random traffic, occasional resets; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = A_W'($urandom);
      b     = B_W'($urandom);
      mode  = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
